salsa20_core: RTL and testbench

- Parametrised Salsa20 hash core, successor to the fixed salsa20/8 block.
- Configurable round count and number of double-rounds unrolled per clock.
- Built-in input XOR (X xor B) for the scrypt BlockMix datapath.
- Single-entry pipeline with start/busy/done handshake; feeds the BlockMix controller.

---
 rtl/salsa20_core.sv | 140 ++++++++++++++
 tb/tb_salsa20_core.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/salsa20_core.sv
// Salsa20 hash core: out = X + DR^(ROUNDS/2)(X), with X = data xor data_x (scrypt BlockMix step).
// Latency: result and hash_done appear NDR+1 edges after the accepting edge; NDR = ROUNDS/(2*DR_PER_CYCLE).
// Backpressure: single entry only; enable is ignored while busy, and nothing is queued.
module salsa20_core #(
    parameter int ROUNDS       = 8,
    parameter int DR_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic [511:0] data,
    input  logic [511:0] data_x,
    output logic [511:0] data_out,
    output logic         hash_done,
    output logic         busy
);

    localparam int NDR = ROUNDS / (2 * DR_PER_CYCLE);
    localparam int CW  = $clog2(NDR) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NDR - 1);

    // Reject round/unroll combinations that cannot be scheduled evenly.
    if (ROUNDS < 2 || (ROUNDS % 2) != 0 || DR_PER_CYCLE < 1 ||
        ((ROUNDS / 2) % DR_PER_CYCLE) != 0) begin : g_bad_params
        $error("salsa20_core: ROUNDS must be even and >= 2, and DR_PER_CYCLE must divide ROUNDS/2");
    end

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FEED
    } state_t;

    state_t         state_q, state_d;
    logic [511:0]   x_q, x_d;
    logic [511:0]   b0_q, b0_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [511:0]   out_q, out_d;
    logic           done_q, done_d;
    logic           busy_q, busy_d;
    logic [511:0]   x_dr;

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // Returns the updated {a, b, c, d} of one Salsa20 quarter-round.
    function automatic logic [127:0] qr(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c, input logic [31:0] d);
        logic [31:0] a1, b1, c1, d1;
        b1 = b ^ rotl(a + d, 7);
        c1 = c ^ rotl(b1 + a, 9);
        d1 = d ^ rotl(c1 + b1, 13);
        a1 = a ^ rotl(d1 + c1, 18);
        return {a1, b1, c1, d1};
    endfunction

    // Column round followed by row round on the little-endian 16-word state.
    function automatic logic [511:0] double_round(input logic [511:0] s);
        logic [31:0]  w [16];
        logic [511:0] r;
        for (int i = 0; i < 16; i++) w[i] = s[32*i +: 32];
        {w[0],  w[4],  w[8],  w[12]} = qr(w[0],  w[4],  w[8],  w[12]);
        {w[5],  w[9],  w[13], w[1]}  = qr(w[5],  w[9],  w[13], w[1]);
        {w[10], w[14], w[2],  w[6]}  = qr(w[10], w[14], w[2],  w[6]);
        {w[15], w[3],  w[7],  w[11]} = qr(w[15], w[3],  w[7],  w[11]);
        {w[0],  w[1],  w[2],  w[3]}  = qr(w[0],  w[1],  w[2],  w[3]);
        {w[5],  w[6],  w[7],  w[4]}  = qr(w[5],  w[6],  w[7],  w[4]);
        {w[10], w[11], w[8],  w[9]}  = qr(w[10], w[11], w[8],  w[9]);
        {w[15], w[12], w[13], w[14]} = qr(w[15], w[12], w[13], w[14]);
        for (int i = 0; i < 16; i++) r[32*i +: 32] = w[i];
        return r;
    endfunction

    // Unrolled chain of DR_PER_CYCLE double-rounds applied to the working state.
    always_comb begin
        x_dr = x_q;
        for (int i = 0; i < DR_PER_CYCLE; i++) x_dr = double_round(x_dr);
    end

    // Next-state and datapath updates; enable is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        b0_d    = b0_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    b0_d    = data ^ data_x;
                    x_d     = data ^ data_x;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                x_d   = x_dr;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) state_d = FEED;
            end
            FEED: begin
                for (int i = 0; i < 16; i++) out_d[32*i +: 32] = x_q[32*i +: 32] + b0_q[32*i +: 32];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset that overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            b0_q    <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            b0_q    <= b0_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign data_out  = out_q;
    assign hash_done = done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_salsa20_core.sv
module tb_salsa20_core;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic [511:0] data, data_x;
    logic [511:0] data_out;
    logic         hash_done, busy;

    logic         en_s   [3];
    logic [511:0] out_s  [3];
    logic         done_s [3];
    logic         busy_s [3];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    logic chk_on = 1'b0;
    int done_q [$];

    always #5 clk = ~clk;

    salsa20_core dut (
        .clk(clk), .rst(rst), .enable(enable), .data(data), .data_x(data_x),
        .data_out(data_out), .hash_done(hash_done), .busy(busy)
    );
    salsa20_core #(.ROUNDS(8), .DR_PER_CYCLE(2)) dut_8_2 (
        .clk(clk), .rst(rst), .enable(en_s[0]), .data(data), .data_x(data_x),
        .data_out(out_s[0]), .hash_done(done_s[0]), .busy(busy_s[0])
    );
    salsa20_core #(.ROUNDS(8), .DR_PER_CYCLE(4)) dut_8_4 (
        .clk(clk), .rst(rst), .enable(en_s[1]), .data(data), .data_x(data_x),
        .data_out(out_s[1]), .hash_done(done_s[1]), .busy(busy_s[1])
    );
    salsa20_core #(.ROUNDS(20), .DR_PER_CYCLE(2)) dut_20_2 (
        .clk(clk), .rst(rst), .enable(en_s[2]), .data(data), .data_x(data_x),
        .data_out(out_s[2]), .hash_done(done_s[2]), .busy(busy_s[2])
    );

    byte unsigned kat_in_b [64] = '{
        8'h7e, 8'h87, 8'h9a, 8'h21, 8'h4f, 8'h3e, 8'hc9, 8'h86, 8'h7c, 8'ha9, 8'h40, 8'he6, 8'h41, 8'h71, 8'h8f, 8'h26,
        8'hba, 8'hee, 8'h55, 8'h5b, 8'h8c, 8'h61, 8'hc1, 8'hb5, 8'h0d, 8'hf8, 8'h46, 8'h11, 8'h6d, 8'hcd, 8'h3b, 8'h1d,
        8'hee, 8'h24, 8'hf3, 8'h19, 8'hdf, 8'h9b, 8'h3d, 8'h85, 8'h14, 8'h12, 8'h1e, 8'h4b, 8'h5a, 8'hc5, 8'haa, 8'h32,
        8'h76, 8'h02, 8'h1d, 8'h29, 8'h09, 8'hc7, 8'h48, 8'h29, 8'hed, 8'heb, 8'hc6, 8'h8d, 8'hb8, 8'hb8, 8'hc2, 8'h5e};
    byte unsigned kat_out_b [64] = '{
        8'ha4, 8'h1f, 8'h85, 8'h9c, 8'h66, 8'h08, 8'hcc, 8'h99, 8'h3b, 8'h81, 8'hca, 8'hcb, 8'h02, 8'h0c, 8'hef, 8'h05,
        8'h04, 8'h4b, 8'h21, 8'h81, 8'ha2, 8'hfd, 8'h33, 8'h7d, 8'hfd, 8'h7b, 8'h1c, 8'h63, 8'h96, 8'h68, 8'h2f, 8'h29,
        8'hb4, 8'h39, 8'h31, 8'h68, 8'he3, 8'hc9, 8'he6, 8'hbc, 8'hfe, 8'h6b, 8'hc5, 8'hb7, 8'ha0, 8'h6d, 8'h96, 8'hba,
        8'he4, 8'h24, 8'hcc, 8'h10, 8'h2c, 8'h91, 8'h74, 8'h5c, 8'h24, 8'had, 8'h67, 8'h3d, 8'hc7, 8'h61, 8'h8f, 8'h81};
    logic [511:0] kat_in, kat_out;

    // Quarter-round word indices (a, b, c, d): four columns, then four rows.
    int qi [32] = '{0, 4, 8, 12,  5, 9, 13, 1,  10, 14, 2, 6,  15, 3, 7, 11,
                    0, 1, 2, 3,   5, 6, 7, 4,   10, 11, 8, 9,  15, 12, 13, 14};

    function automatic int unsigned rl(input int unsigned v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [511:0] salsa_model(input logic [511:0] inb, input int rounds);
        int unsigned x [16];
        int unsigned orig [16];
        logic [511:0] r;
        int a, b, c, d;
        for (int i = 0; i < 16; i++) begin
            orig[i] = inb[32*i +: 32];
            x[i]    = orig[i];
        end
        for (int rr = 0; rr < rounds; rr += 2) begin
            for (int q = 0; q < 8; q++) begin
                a = qi[4*q]; b = qi[4*q+1]; c = qi[4*q+2]; d = qi[4*q+3];
                x[b] ^= rl(x[a] + x[d], 7);
                x[c] ^= rl(x[b] + x[a], 9);
                x[d] ^= rl(x[c] + x[b], 13);
                x[a] ^= rl(x[d] + x[c], 18);
            end
        end
        for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + orig[i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Transaction-level model of the default core: a hash occupies NDR+1 edges after acceptance.
    localparam int MAIN_NDR = 4;
    int           m_left = 0;
    logic [511:0] m_pending = '0;
    logic [511:0] m_out = '0;
    logic         m_done = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_left = 0;
            m_out  = '0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left == 0) begin
                if (enable) begin
                    m_pending = salsa_model(data ^ data_x, 8);
                    m_left    = MAIN_NDR + 1;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_out  = m_pending;
                    m_done = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison of the default core against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("cyc_hash_done", {511'b0, hash_done}, {511'b0, m_done});
            chk("cyc_busy", {511'b0, busy}, {511'b0, (m_left != 0)});
            chk("cyc_data_out", data_out, m_out);
            if (hash_done) done_q.push_back(cyc);
        end
    end

    task automatic run_one(input logic [511:0] a, input logic [511:0] b,
                           output int lat, output int bc, output logic [511:0] res);
        int s;
        @(negedge clk);
        data = a; data_x = b; enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        s = cyc; lat = -1; bc = 0; res = '0;
        for (int i = 0; i < 30; i++) begin
            if (busy) bc++;
            if (hash_done && lat < 0) begin
                lat = cyc - s;
                res = data_out;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_sweep(input int k, input int exp_lat, input logic [511:0] exp_out);
        int s, lat;
        logic [511:0] res;
        @(negedge clk);
        data = kat_in; data_x = '0; en_s[k] = 1'b1;
        @(negedge clk);
        en_s[k] = 1'b0;
        s = cyc; lat = -1; res = '0;
        for (int i = 0; i < 30; i++) begin
            if (done_s[k] && lat < 0) begin
                lat = cyc - s;
                res = out_s[k];
            end
            @(negedge clk);
        end
        chk($sformatf("sweep%0d_latency", k), 512'(lat), 512'(exp_lat));
        chk($sformatf("sweep%0d_result", k), res, exp_out);
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        int lat, bc, s;
        logic [511:0] res, pat, r;
        for (int k = 0; k < 64; k++) begin
            kat_in[8*k +: 8]  = kat_in_b[k];
            kat_out[8*k +: 8] = kat_out_b[k];
        end
        rst = 1'b1; enable = 1'b0; data = '0; data_x = '0;
        for (int k = 0; k < 3; k++) en_s[k] = 1'b0;

        // Pin the reference model itself to the published vector.
        chk("model_kat", salsa_model(kat_in, 8), kat_out);

        @(negedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        chk("reset_data_out", data_out, '0);
        chk("reset_busy", {511'b0, busy}, '0);
        chk("reset_hash_done", {511'b0, hash_done}, '0);
        chk("reset_sweep_out", out_s[2], '0);
        rst = 1'b0;

        // Known answer.
        run_one(kat_in, '0, lat, bc, res);
        chk("kat_latency", 512'(lat), 512'(5));
        chk("kat_busy_cycles", 512'(bc), 512'(5));
        chk("kat_result", res, kat_out);

        // Idle hold: inputs move, enable low.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            data = rand512(); data_x = rand512();
        end
        chk("hold_data_out", data_out, kat_out);

        // XOR mode.
        pat = {16{32'hA5A5_5A5A}};
        run_one(kat_in ^ pat, pat, lat, bc, res);
        chk("xor_latency", 512'(lat), 512'(5));
        chk("xor_result", res, kat_out);

        // Busy pulse ignored, then enable held across hash_done.
        r = rand512();
        @(negedge clk);
        data = r; data_x = '0; enable = 1'b1; done_q.delete();
        @(negedge clk);
        enable = 1'b0; s = cyc;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        enable = 1'b0;
        repeat (12) @(negedge clk);
        chk("b2b_done_count", 512'(done_q.size()), 512'(2));
        if (done_q.size() >= 2) begin
            chk("b2b_first_latency", 512'(done_q[0] - s), 512'(5));
            chk("b2b_spacing", 512'(done_q[1] - done_q[0]), 512'(6));
        end
        chk("b2b_result", data_out, salsa_model(r, 8));

        // Reset two edges into a hash.
        @(negedge clk);
        data = kat_in; data_x = '0; enable = 1'b1; done_q.delete();
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort_no_done", 512'(done_q.size()), 512'(0));
        chk("abort_data_out", data_out, '0);
        chk("abort_busy", {511'b0, busy}, '0);
        run_one(kat_in, '0, lat, bc, res);
        chk("after_abort_latency", 512'(lat), 512'(5));
        chk("after_abort_result", res, kat_out);

        // Random traffic with occasional resets, checked cycle by cycle.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            enable = ($urandom_range(0, 2) == 0);
            rst    = ($urandom_range(0, 79) == 0);
            data   = rand512();
            data_x = ($urandom_range(0, 1) == 0) ? '0 : rand512();
        end
        @(negedge clk);
        enable = 1'b0; rst = 1'b0;
        repeat (10) @(negedge clk);

        // Parameter sweep.
        run_sweep(0, 3, kat_out);
        run_sweep(1, 2, kat_out);
        run_sweep(2, 6, salsa_model(kat_in, 20));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
